// File: rtl/rob_multiport_pkg.sv
// Shared types for the reorder buffer: the entry payload and the exception record it carries.
package rob_multiport_pkg;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cause;
        logic [31:0] tval;
    } riscv_exception_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic [4:0]       rd_addr;
        logic             rd_we;
        logic [31:0]      rd_value;
        riscv_exception_t exc;
    } rob_item_t;

endpackage

// File: rtl/rob_ready_prefix.sv
// Leading-ones counter: length of the unbroken run of set bits starting at bit 0.
module rob_ready_prefix #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] cnt
);

    logic run;

    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < W; i++) begin
            run = run & bits[i];
            if (run) cnt = CW'(i + 1);
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: wide rename allocation, per-port writeback/finish, in-order
// multi-retire, and tail truncation on mispredict plus full flush.
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int DEPTH        = 32,
    parameter int RENAME_WIDTH = 4,
    parameter int WB_WIDTH     = 4,
    parameter int COMMIT_WIDTH = 4,
    parameter int ID_W         = $clog2(DEPTH),
    parameter int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    output logic [RENAME_WIDTH-1:0][ID_W-1:0]            rob_rename_new_id,
    output logic [RENAME_WIDTH-1:0]                      rob_rename_new_id_valid,
    input  rob_item_t [RENAME_WIDTH-1:0]                 rename_rob_data,
    input  logic [RENAME_WIDTH-1:0]                      rename_rob_data_valid,
    input  logic                                         rename_rob_push,
    output logic                                         rob_rename_ready,
    input  logic [WB_WIDTH-1:0][ID_W-1:0]                commit_rob_input_id,
    output rob_item_t [WB_WIDTH-1:0]                     rob_commit_input_data,
    input  rob_item_t [WB_WIDTH-1:0]                     commit_rob_input_data,
    input  logic [WB_WIDTH-1:0]                          commit_rob_input_data_we,
    output logic [COMMIT_WIDTH-1:0][ID_W-1:0]            rob_commit_head_id,
    output rob_item_t [COMMIT_WIDTH-1:0]                 rob_commit_head_data,
    output logic [COMMIT_WIDTH-1:0]                      rob_commit_head_valid,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0]            rob_commit_ready_cnt,
    input  logic [$clog2(COMMIT_WIDTH+1)-1:0]            commit_rob_retire_cnt,
    input  logic                                         commit_rob_truncate,
    input  logic [ID_W-1:0]                              commit_rob_truncate_id,
    input  logic                                         commit_rob_flush,
    output logic [CNT_W-1:0]                             rob_commit_count,
    output logic                                         rob_commit_empty,
    output logic                                         rob_commit_full
);

    localparam int RC_W = $clog2(COMMIT_WIDTH + 1);
    localparam int RN_W = $clog2(RENAME_WIDTH + 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]            finish_q, finish_d;
    rob_item_t [DEPTH-1:0]       ram_q, ram_d;

    logic [CNT_W-1:0]            count, free_cnt;
    logic [COMMIT_WIDTH-1:0]     rdy_win;
    logic [RN_W-1:0]             push_cnt;
    logic [RC_W-1:0]             pop_n;
    logic [ID_W-1:0]             trunc_off;

    assign count            = tail_q - head_q;
    assign free_cnt         = CNT_W'(DEPTH) - count;
    assign rob_commit_count = count;
    assign rob_commit_empty = (count == '0);
    assign rob_commit_full  = (count == CNT_W'(DEPTH));
    assign rob_rename_ready = (CNT_W'(push_cnt) <= free_cnt);
    assign trunc_off        = commit_rob_truncate_id - head_q[ID_W-1:0];

    for (genvar k = 0; k < RENAME_WIDTH; k++) begin : g_ren
        assign rob_rename_new_id[k]       = tail_q[ID_W-1:0] + ID_W'(k);
        assign rob_rename_new_id_valid[k] = (CNT_W'(k) < free_cnt);
    end

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_head
        assign rob_commit_head_id[k]    = head_q[ID_W-1:0] + ID_W'(k);
        assign rob_commit_head_data[k]  = ram_q[rob_commit_head_id[k]];
        assign rob_commit_head_valid[k] = (count > CNT_W'(k));
        assign rdy_win[k]               = rob_commit_head_valid[k] & finish_q[rob_commit_head_id[k]];
    end

    for (genvar w = 0; w < WB_WIDTH; w++) begin : g_wb_rd
        assign rob_commit_input_data[w] = ram_q[commit_rob_input_id[w]];
    end

    rob_ready_prefix #(.W(COMMIT_WIDTH)) u_ready (
        .bits (rdy_win),
        .cnt  (rob_commit_ready_cnt)
    );

    // The rename mask is a contiguous prefix, so its leading-ones run equals its popcount.
    rob_ready_prefix #(.W(RENAME_WIDTH)) u_push_cnt (
        .bits (rename_rob_data_valid),
        .cnt  (push_cnt)
    );

    assign pop_n = (commit_rob_retire_cnt < rob_commit_ready_cnt) ? commit_rob_retire_cnt
                                                                  : rob_commit_ready_cnt;

    always_comb begin
        logic [ID_W-1:0] idx;
        head_d   = head_q;
        tail_d   = tail_q;
        finish_d = finish_q;
        ram_d    = ram_q;
        idx      = '0;
        if (commit_rob_flush) begin
            head_d   = '0;
            tail_d   = '0;
            finish_d = '0;
        end else begin
            // Ascending port order lets the highest-indexed writer win a same-id collision.
            for (int w = 0; w < WB_WIDTH; w++) begin
                idx = commit_rob_input_id[w] - head_q[ID_W-1:0];
                if (commit_rob_input_data_we[w] && (CNT_W'(idx) < count)) begin
                    ram_d[commit_rob_input_id[w]]    = commit_rob_input_data[w];
                    finish_d[commit_rob_input_id[w]] = 1'b1;
                end
            end
            head_d = head_q + CNT_W'(pop_n);
            if (commit_rob_truncate) begin
                if (CNT_W'(trunc_off) < count) begin
                    if (CNT_W'(trunc_off) < CNT_W'(pop_n)) tail_d = head_d;
                    else tail_d = head_q + CNT_W'(trunc_off) + CNT_W'(1);
                end
            end else if (rename_rob_push && rob_rename_ready) begin
                for (int k = 0; k < RENAME_WIDTH; k++) begin
                    idx = tail_q[ID_W-1:0] + ID_W'(k);
                    if (rename_rob_data_valid[k]) begin
                        ram_d[idx]    = rename_rob_data[k];
                        finish_d[idx] = 1'b0;
                    end
                end
                tail_d = tail_q + CNT_W'(push_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            finish_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            finish_q <= finish_d;
        end
    end

    always_ff @(posedge clk) begin
        ram_q <= ram_d;
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport at DEPTH=16: a cycle-by-cycle vector table plus a full-ROB sequence.
module tb_rob_multiport;
    import rob_multiport_pkg::*;

    localparam int DEPTH = 16;
    localparam int RW    = 4;
    localparam int WW    = 4;
    localparam int CW    = 4;
    localparam int ID_W  = 4;
    localparam int CNT_W = 5;
    localparam int RC_W  = 3;
    localparam int NV    = 36;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [RW-1:0][ID_W-1:0]   rob_rename_new_id;
    logic [RW-1:0]             rob_rename_new_id_valid;
    rob_item_t [RW-1:0]        rename_rob_data;
    logic [RW-1:0]             rename_rob_data_valid;
    logic                      rename_rob_push;
    logic                      rob_rename_ready;
    logic [WW-1:0][ID_W-1:0]   commit_rob_input_id;
    rob_item_t [WW-1:0]        rob_commit_input_data;
    rob_item_t [WW-1:0]        commit_rob_input_data;
    logic [WW-1:0]             commit_rob_input_data_we;
    logic [CW-1:0][ID_W-1:0]   rob_commit_head_id;
    rob_item_t [CW-1:0]        rob_commit_head_data;
    logic [CW-1:0]             rob_commit_head_valid;
    logic [RC_W-1:0]           rob_commit_ready_cnt;
    logic [RC_W-1:0]           commit_rob_retire_cnt;
    logic                      commit_rob_truncate;
    logic [ID_W-1:0]           commit_rob_truncate_id;
    logic                      commit_rob_flush;
    logic [CNT_W-1:0]          rob_commit_count;
    logic                      rob_commit_empty;
    logic                      rob_commit_full;

    rob_multiport #(.DEPTH(DEPTH), .RENAME_WIDTH(RW), .WB_WIDTH(WW), .COMMIT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .rob_rename_new_id(rob_rename_new_id), .rob_rename_new_id_valid(rob_rename_new_id_valid),
        .rename_rob_data(rename_rob_data), .rename_rob_data_valid(rename_rob_data_valid),
        .rename_rob_push(rename_rob_push), .rob_rename_ready(rob_rename_ready),
        .commit_rob_input_id(commit_rob_input_id), .rob_commit_input_data(rob_commit_input_data),
        .commit_rob_input_data(commit_rob_input_data), .commit_rob_input_data_we(commit_rob_input_data_we),
        .rob_commit_head_id(rob_commit_head_id), .rob_commit_head_data(rob_commit_head_data),
        .rob_commit_head_valid(rob_commit_head_valid), .rob_commit_ready_cnt(rob_commit_ready_cnt),
        .commit_rob_retire_cnt(commit_rob_retire_cnt), .commit_rob_truncate(commit_rob_truncate),
        .commit_rob_truncate_id(commit_rob_truncate_id), .commit_rob_flush(commit_rob_flush),
        .rob_commit_count(rob_commit_count), .rob_commit_empty(rob_commit_empty),
        .rob_commit_full(rob_commit_full)
    );

    always #5 clk = ~clk;

    // One row = inputs held for one cycle, then the expected state after that edge.
    // in0/hpc of zero mean "don't compare" for the data-path checks.
    typedef struct {
        bit          rst_n;
        bit          push;
        int          nv;
        logic [31:0] pc0;
        logic [3:0]  we;
        int          id0, id1, id2, id3;
        int          ret;
        bit          tr;
        int          tid;
        bit          fl;
        int          c, r, nid, hid;
        logic [31:0] in0, hpc;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(bit rn, bit p, int nv, logic [31:0] pc0, logic [3:0] we,
                                int i0, int i1, int i2, int i3, int ret, bit tr, int tid, bit fl,
                                int c, int r, int nid, int hid, logic [31:0] in0, logic [31:0] hpc);
        vec_t v;
        v.rst_n = rn; v.push = p; v.nv = nv; v.pc0 = pc0; v.we = we;
        v.id0 = i0; v.id1 = i1; v.id2 = i2; v.id3 = i3; v.ret = ret;
        v.tr = tr; v.tid = tid; v.fl = fl;
        v.c = c; v.r = r; v.nid = nid; v.hid = hid; v.in0 = in0; v.hpc = hpc;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL row %0d %s: got %0h expected %0h", row, nm, act, exp);
        end
    endtask

    // Writeback payload pc encodes row, port and id so every write is traceable.
    task automatic apply(input vec_t v, input int row);
        int ids [4];
        ids = '{v.id0, v.id1, v.id2, v.id3};
        rst                   = v.rst_n;
        rename_rob_push       = v.push;
        rename_rob_data_valid = RW'((1 << v.nv) - 1);
        for (int k = 0; k < RW; k++) begin
            rename_rob_data[k]    = '0;
            rename_rob_data[k].pc = v.pc0 + 32'(k);
        end
        commit_rob_input_data_we = v.we;
        for (int w = 0; w < WW; w++) begin
            commit_rob_input_id[w]      = ID_W'(ids[w]);
            commit_rob_input_data[w]    = '0;
            commit_rob_input_data[w].pc = 32'hF000_0000 + 32'(row * 256 + w * 16 + ids[w]);
        end
        commit_rob_retire_cnt  = RC_W'(v.ret);
        commit_rob_truncate    = v.tr;
        commit_rob_truncate_id = ID_W'(v.tid);
        commit_rob_flush       = v.fl;
        @(posedge clk);
        #1;
    endtask

    task automatic verify(input vec_t v, input int row);
        logic [3:0] e_nidv, e_hv;
        for (int k = 0; k < 4; k++) begin
            e_nidv[k] = (k < DEPTH - v.c);
            e_hv[k]   = (k < v.c);
        end
        chk("count", row, 32'(rob_commit_count), 32'(v.c));
        chk("ready_cnt", row, 32'(rob_commit_ready_cnt), 32'(v.r));
        chk("new_id0", row, 32'(rob_rename_new_id[0]), 32'(v.nid));
        chk("head_id0", row, 32'(rob_commit_head_id[0]), 32'(v.hid));
        chk("empty", row, 32'(rob_commit_empty), 32'(v.c == 0));
        chk("full", row, 32'(rob_commit_full), 32'(v.c == DEPTH));
        chk("rename_ready", row, 32'(rob_rename_ready), 32'(v.nv <= DEPTH - v.c));
        chk("new_id_valid", row, 32'(rob_rename_new_id_valid), 32'(e_nidv));
        chk("head_valid", row, 32'(rob_commit_head_valid), 32'(e_hv));
        if (v.in0 != 0) chk("input_data0", row, rob_commit_input_data[0].pc, v.in0);
        if (v.hpc != 0) chk("head_data0", row, rob_commit_head_data[0].pc, v.hpc);
    endtask

    initial begin
        //               rn p nv pc0   we    ids          ret tr tid fl  c  r nid hid in0            hpc
        vecs[0]  = mk(0, 0, 0, 0,     4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,            0);
        vecs[1]  = mk(1, 1, 4, 'h100, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 4, 0, 0,            'h100);
        vecs[2]  = mk(1, 1, 4, 'h104, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  8, 0, 8, 0, 0,            0);
        vecs[3]  = mk(1, 0, 0, 0,     4'h7, 0, 1, 3, 0,  0, 0, 0, 0,  8, 2, 8, 0, 'hF000_0300, 0);
        vecs[4]  = mk(1, 0, 0, 0,     4'h0, 0, 0, 0, 0,  4, 0, 0, 0,  6, 0, 8, 2, 0,            'h102);
        vecs[5]  = mk(1, 1, 4, 'h108, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0, 10, 0,12, 2, 0,            0);
        vecs[6]  = mk(1, 1, 4, 'h10C, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0, 14, 0, 0, 2, 0,            0);
        vecs[7]  = mk(1, 1, 2, 'h110, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0, 16, 0, 2, 2, 0,            0);
        vecs[8]  = mk(1, 1, 1, 'h120, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0, 16, 0, 2, 2, 0,            0);
        vecs[9]  = mk(1, 0, 0, 0,     4'hF, 2, 4, 5, 6,  0, 0, 0, 0, 16, 4, 2, 2, 0,            0);
        vecs[10] = mk(1, 0, 0, 0,     4'hF, 7, 8, 9,10,  0, 0, 0, 0, 16, 4, 2, 2, 0,            0);
        vecs[11] = mk(1, 0, 0, 0,     4'hF,11,12,13,14,  0, 0, 0, 0, 16, 4, 2, 2, 0,            0);
        vecs[12] = mk(1, 0, 0, 0,     4'hF,15, 0, 1, 3,  0, 0, 0, 0, 16, 4, 2, 2, 0,            0);
        vecs[13] = mk(1, 0, 0, 0,     4'h0, 0, 0, 0, 0,  4, 0, 0, 0, 12, 4, 2, 6, 0,            0);
        vecs[14] = mk(1, 0, 0, 0,     4'h0, 0, 0, 0, 0,  4, 0, 0, 0,  8, 4, 2,10, 0,            0);
        vecs[15] = mk(1, 0, 0, 0,     4'h0, 0, 0, 0, 0,  4, 0, 0, 0,  4, 4, 2,14, 0,            0);
        vecs[16] = mk(1, 0, 0, 0,     4'h0, 0, 0, 0, 0,  4, 0, 0, 0,  0, 0, 2, 2, 0,            0);
        vecs[17] = mk(1, 1, 4, 'h200, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 6, 2, 0,            'h200);
        vecs[18] = mk(1, 1, 4, 'h204, 4'hF, 2, 3, 4, 5,  0, 0, 0, 0,  8, 4,10, 2, 0,            0);
        vecs[19] = mk(1, 1, 4, 'h208, 4'hF, 6, 7, 8, 9,  4, 0, 0, 0,  8, 4,14, 6, 0,            0);
        vecs[20] = mk(1, 0, 0, 0,     4'hF,10,11,12,13,  4, 0, 0, 0,  4, 4,14,10, 0,            0);
        vecs[21] = mk(1, 0, 0, 0,     4'h0, 0, 0, 0, 0,  4, 0, 0, 0,  0, 0,14,14, 0,            0);
        vecs[22] = mk(1, 1, 4, 'h300, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 2,14, 0,            'h300);
        vecs[23] = mk(1, 0, 0, 0,     4'h1,15, 0, 0, 0,  0, 0, 0, 0,  4, 0, 2,14, 'hF000_170F, 0);
        vecs[24] = mk(1, 0, 0, 0,     4'h1, 2, 0, 0, 0,  0, 0, 0, 0,  4, 0, 2,14, 'hF000_1202, 0);
        vecs[25] = mk(1, 0, 0, 0,     4'h3,14,14, 0, 0,  0, 0, 0, 0,  4, 2, 2,14, 'hF000_191E, 'hF000_191E);
        vecs[26] = mk(1, 1, 4, 'h3A0, 4'h1, 0, 0, 0, 0,  4, 1,15, 1,  0, 0, 0, 0, 0,            0);
        vecs[27] = mk(1, 1, 4, 'h400, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 4, 0, 0,            'h400);
        vecs[28] = mk(1, 1, 4, 'h404, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  8, 0, 8, 0, 0,            0);
        vecs[29] = mk(1, 1, 2, 'h408, 4'h3, 0, 1, 0, 0,  0, 0, 0, 0, 10, 2,10, 0, 0,            0);
        vecs[30] = mk(1, 1, 4, 'h500, 4'h0, 0, 0, 0, 0,  2, 1, 5, 0,  4, 0, 6, 2, 0,            'h402);
        vecs[31] = mk(1, 0, 0, 0,     4'h3, 2, 3, 0, 0,  0, 0, 0, 0,  4, 2, 6, 2, 0,            0);
        vecs[32] = mk(1, 0, 0, 0,     4'h0, 0, 0, 0, 0,  2, 1, 2, 0,  0, 0, 4, 4, 0,            0);
        vecs[33] = mk(1, 1, 4, 'h600, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 8, 4, 0,            'h600);
        vecs[34] = mk(1, 0, 0, 0,     4'h0, 0, 0, 0, 0,  0, 1,10, 0,  4, 0, 8, 4, 0,            0);
        vecs[35] = mk(0, 1, 4, 'h680, 4'h0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,            0);

        rename_rob_push = 0; rename_rob_data_valid = '0; rename_rob_data = '0;
        commit_rob_input_id = '0; commit_rob_input_data = '0; commit_rob_input_data_we = '0;
        commit_rob_retire_cnt = '0; commit_rob_truncate = 0; commit_rob_truncate_id = '0;
        commit_rob_flush = 0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
            verify(vecs[i], i);
        end

        // Fill from reset, finish everything, then push+retire at full: push must be refused.
        for (int i = 0; i < 4; i++)
            apply(mk(1, 1, 4, 32'h700 + 32'(4 * i), 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 40 + i);
        for (int i = 0; i < 4; i++)
            apply(mk(1, 0, 0, 0, 4'hF, 4 * i, 4 * i + 1, 4 * i + 2, 4 * i + 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 44 + i);
        chk("seq full count", 48, 32'(rob_commit_count), 32'd16);
        chk("seq full flag", 48, 32'(rob_commit_full), 32'd1);
        chk("seq full ready", 48, 32'(rob_commit_ready_cnt), 32'd4);
        apply(mk(1, 1, 4, 32'h800, 4'h0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0), 48);
        chk("seq pop count", 49, 32'(rob_commit_count), 32'd12);
        chk("seq pop new_id0", 49, 32'(rob_rename_new_id[0]), 32'd0);
        chk("seq pop head_id0", 49, 32'(rob_commit_head_id[0]), 32'd4);
        apply(mk(1, 1, 4, 32'h900, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 49);
        chk("seq refill count", 50, 32'(rob_commit_count), 32'd16);
        chk("seq refill new_id0", 50, 32'(rob_rename_new_id[0]), 32'd4);
        chk("seq head_id1", 50, 32'(rob_commit_head_id[1]), 32'd5);
        chk("seq head_id3", 50, 32'(rob_commit_head_id[3]), 32'd7);
        chk("seq head_data1", 50, rob_commit_head_data[1].pc, 32'hF000_2D15);
        chk("seq wrapped data", 50, rob_commit_head_data[0].pc, 32'hF000_2D04);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
